// File: rtl/soc_addr_decoder.sv
// Runtime-programmable SoC address decoder: region table, one-stage registered lookup.
// Optional decode-miss counter enabled by defining SOC_ADDR_DECODER_MISS_CNT_EN.
module soc_addr_decoder #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned NUM_SLAVES  = 9,
    parameter int unsigned NUM_RULES   = 9,
    parameter int unsigned IDX_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    parameter int unsigned RULE_W      = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
    parameter int unsigned DEFAULT_IDX = 0,
    // Element 0 is rule 0 (DRAM) ... element 8 is rule 8 (Debug)
    parameter logic [NUM_RULES-1:0][ADDR_WIDTH-1:0] RESET_BASE = {
        64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000, 64'h1000_0000,
        64'h2000_0000, 64'h3000_0000, 64'h4000_0000, 64'h8000_0000},
    parameter logic [NUM_RULES-1:0][ADDR_WIDTH-1:0] RESET_LEN = {
        64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF, 64'h0000_1000,
        64'h0080_0000, 64'h0001_0000, 64'h0000_1000, 64'h4000_0000},
    parameter logic [NUM_RULES-1:0][31:0] RESET_IDX = {
        32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [IDX_W-1:0]      resp_idx_o,
    output logic                  resp_decerr_o,
    output logic [ADDR_WIDTH-1:0] resp_addr_o,
    input  logic                  cfg_we_i,
    input  logic [RULE_W-1:0]     cfg_rule_i,
    input  logic [ADDR_WIDTH-1:0] cfg_base_i,
    input  logic [ADDR_WIDTH-1:0] cfg_len_i,
    input  logic [IDX_W-1:0]      cfg_idx_i,
    input  logic                  cfg_lock_i,
    output logic                  cfg_err_o,
    output logic                  locked_o,
    output logic [31:0]           miss_cnt_o
);

    logic [ADDR_WIDTH-1:0] r_base [NUM_RULES];
    logic [ADDR_WIDTH-1:0] r_len  [NUM_RULES];
    logic [IDX_W-1:0]      r_idx  [NUM_RULES];
    logic                  r_locked;
    logic                  r_cfg_err;
    logic                  r_resp_valid;
    logic                  r_resp_decerr;
    logic [IDX_W-1:0]      r_resp_idx;
    logic [ADDR_WIDTH-1:0] r_resp_addr;

    logic [NUM_RULES-1:0]  w_match;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_req_fire;
    logic                  w_rule_oob;
    logic                  w_cfg_ok;

    assign req_ready_o = !r_resp_valid || resp_ready_i;
    assign w_req_fire  = req_valid_i && req_ready_o;
    assign w_rule_oob  = (32'(cfg_rule_i) >= NUM_RULES);
    assign w_cfg_ok    = cfg_we_i && !r_locked && !w_rule_oob;

    // End address kept one bit wider so a region reaching 2^ADDR_WIDTH covers the top address
    for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule
        logic [ADDR_WIDTH:0] w_end;
        assign w_end      = {1'b0, r_base[g]} + {1'b0, r_len[g]};
        assign w_match[g] = (r_len[g] != '0) && (req_addr_i >= r_base[g]) &&
                            ({1'b0, req_addr_i} < w_end);
    end

    // Scan high to low so the lowest-numbered matching rule wins
    always_comb begin
        w_hit = 1'b0;
        w_idx = IDX_W'(DEFAULT_IDX);
        for (int r = NUM_RULES - 1; r >= 0; r--) begin
            if (w_match[r]) begin
                w_hit = 1'b1;
                w_idx = r_idx[r];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                r_base[r] <= RESET_BASE[r];
                r_len[r]  <= RESET_LEN[r];
                r_idx[r]  <= RESET_IDX[r][IDX_W-1:0];
            end
            r_locked  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            if (w_cfg_ok) begin
                r_base[cfg_rule_i] <= cfg_base_i;
                r_len[cfg_rule_i]  <= cfg_len_i;
                r_idx[cfg_rule_i]  <= cfg_idx_i;
            end
            r_locked  <= r_locked || cfg_lock_i;
            r_cfg_err <= cfg_we_i && (r_locked || w_rule_oob);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_valid  <= 1'b0;
            r_resp_idx    <= '0;
            r_resp_decerr <= 1'b0;
            r_resp_addr   <= '0;
        end else if (w_req_fire) begin
            r_resp_valid  <= 1'b1;
            r_resp_idx    <= w_idx;
            r_resp_decerr <= !w_hit;
            r_resp_addr   <= req_addr_i;
        end else if (resp_ready_i) begin
            r_resp_valid  <= 1'b0;
        end
    end

`ifdef SOC_ADDR_DECODER_MISS_CNT_EN
    logic [31:0] r_miss_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_miss_cnt <= '0;
        else if (w_req_fire && !w_hit && r_miss_cnt != 32'hFFFF_FFFF)
            r_miss_cnt <= r_miss_cnt + 32'd1;
    end
    assign miss_cnt_o = r_miss_cnt;
`else
    assign miss_cnt_o = '0;
`endif

    assign resp_valid_o  = r_resp_valid;
    assign resp_idx_o    = r_resp_idx;
    assign resp_decerr_o = r_resp_decerr;
    assign resp_addr_o   = r_resp_addr;
    assign cfg_err_o     = r_cfg_err;
    assign locked_o      = r_locked;

endmodule

// File: tb/tb_soc_addr_decoder.sv
// Directed bench for soc_addr_decoder: reset-map vector table plus config/lock/backpressure sequences.
module tb_soc_addr_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_idx;
    logic        resp_decerr;
    logic [63:0] resp_addr;
    logic        cfg_we;
    logic [3:0]  cfg_rule;
    logic [63:0] cfg_base;
    logic [63:0] cfg_len;
    logic [3:0]  cfg_idx;
    logic        cfg_lock;
    logic        cfg_err;
    logic        locked;
    logic [31:0] miss_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_miss = 0;

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  idx;
        logic        err;
    } vec_t;
    vec_t vecs[16];

    soc_addr_decoder dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_idx_o(resp_idx),
        .resp_decerr_o(resp_decerr), .resp_addr_o(resp_addr),
        .cfg_we_i(cfg_we), .cfg_rule_i(cfg_rule), .cfg_base_i(cfg_base),
        .cfg_len_i(cfg_len), .cfg_idx_i(cfg_idx), .cfg_lock_i(cfg_lock),
        .cfg_err_o(cfg_err), .locked_o(locked), .miss_cnt_o(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_miss(input string name);
`ifdef SOC_ADDR_DECODER_MISS_CNT_EN
        chk(name, 64'(miss_cnt), 64'(exp_miss));
`else
        chk(name, 64'(miss_cnt), 64'd0);
`endif
    endtask

    // Single lookup with resp_ready high; result checked one cycle later
    task automatic lookup(input string name, input logic [63:0] a,
                          input logic [3:0] idx, input logic err);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        if (err) exp_miss++;
        chk({name, ".valid"}, 64'(resp_valid), 64'd1);
        chk({name, ".idx"}, 64'(resp_idx), 64'(idx));
        chk({name, ".decerr"}, 64'(resp_decerr), 64'(err));
        chk({name, ".addr"}, resp_addr, a);
        chk_miss({name, ".miss"});
    endtask

    task automatic cfg_write(input logic [3:0] rule, input logic [63:0] b,
                             input logic [63:0] l, input logic [3:0] ix, input logic lk);
        cfg_we   = 1'b1;
        cfg_rule = rule;
        cfg_base = b;
        cfg_len  = l;
        cfg_idx  = ix;
        cfg_lock = lk;
        step();
        cfg_we   = 1'b0;
        cfg_lock = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_miss = 0;
    endtask

    initial begin
        vecs[0]  = '{64'h8000_1000, 4'd0, 1'b0};
        vecs[1]  = '{64'h1000_0FFF, 4'd4, 1'b0};
        vecs[2]  = '{64'h0000_0800, 4'd8, 1'b0};
        vecs[3]  = '{64'h1000_1000, 4'd0, 1'b1};
        vecs[4]  = '{64'h1000_1004, 4'd0, 1'b1};
        vecs[5]  = '{64'h4000_0FFF, 4'd1, 1'b0};
        vecs[6]  = '{64'h3000_FFFF, 4'd2, 1'b0};
        vecs[7]  = '{64'h207F_FFFF, 4'd3, 1'b0};
        vecs[8]  = '{64'h0FFF_FFFE, 4'd5, 1'b0};
        vecs[9]  = '{64'h0FFF_FFFF, 4'd0, 1'b1};
        vecs[10] = '{64'h020B_FFFF, 4'd6, 1'b0};
        vecs[11] = '{64'h020C_0000, 4'd0, 1'b1};
        vecs[12] = '{64'h0001_FFFF, 4'd7, 1'b0};
        vecs[13] = '{64'hBFFF_FFFF, 4'd0, 1'b0};
        vecs[14] = '{64'hC000_0000, 4'd0, 1'b1};
        vecs[15] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b1};

        req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
        cfg_we = 1'b0; cfg_rule = '0; cfg_base = '0; cfg_len = '0; cfg_idx = '0; cfg_lock = 1'b0;
        do_reset();

        chk("rst.valid", 64'(resp_valid), 64'd0);
        chk("rst.idx", 64'(resp_idx), 64'd0);
        chk("rst.decerr", 64'(resp_decerr), 64'd0);
        chk("rst.addr", resp_addr, 64'd0);
        chk("rst.cfg_err", 64'(cfg_err), 64'd0);
        chk("rst.locked", 64'(locked), 64'd0);
        chk("rst.ready", 64'(req_ready), 64'd1);
        chk_miss("rst.miss");

        for (int i = 0; i < 16; i++)
            lookup($sformatf("vec%0d", i), vecs[i].addr, vecs[i].idx, vecs[i].err);
        step();
        chk("idle.valid", 64'(resp_valid), 64'd0);

        // Backpressure: first result held while resp_ready low, then two results back to back
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 64'h4000_0000;
        step();
        req_addr   = 64'h2000_0000;
        for (int c = 0; c < 3; c++) begin
            chk("bp.ready", 64'(req_ready), 64'd0);
            chk("bp.valid", 64'(resp_valid), 64'd1);
            chk("bp.idx", 64'(resp_idx), 64'd1);
            chk("bp.addr", resp_addr, 64'h4000_0000);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp.ready_pass", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        chk("bp.second.valid", 64'(resp_valid), 64'd1);
        chk("bp.second.idx", 64'(resp_idx), 64'd3);
        chk("bp.second.addr", resp_addr, 64'h2000_0000);
        step();
        chk("bp.drain", 64'(resp_valid), 64'd0);

        // Write rule 0 while a DRAM request is accepted: that request still sees the old table
        req_valid = 1'b1;
        req_addr  = 64'h8000_0000;
        cfg_write(4'd0, 64'h1000_0000, 64'h10, 4'd2, 1'b0);
        req_valid = 1'b0;
        chk("wr.old_table.idx", 64'(resp_idx), 64'd0);
        chk("wr.old_table.decerr", 64'(resp_decerr), 64'd0);
        chk("wr.cfg_err", 64'(cfg_err), 64'd0);
        lookup("ovl.in", 64'h1000_0008, 4'd2, 1'b0);
        lookup("ovl.out", 64'h1000_0010, 4'd4, 1'b0);
        lookup("dram.gone", 64'h8000_0000, 4'd0, 1'b1);

        // Out-of-range rule index
        cfg_write(4'd9, 64'h0, 64'h0, 4'd0, 1'b0);
        chk("oob.err", 64'(cfg_err), 64'd1);
        step();
        chk("oob.err_clear", 64'(cfg_err), 64'd0);
        lookup("oob.unchanged", 64'h1000_0008, 4'd2, 1'b0);

        // Region ending exactly at 2^64
        cfg_write(4'd1, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'd6, 1'b0);
        chk("top.cfg_err", 64'(cfg_err), 64'd0);
        lookup("top.last", 64'hFFFF_FFFF_FFFF_FFFF, 4'd6, 1'b0);
        lookup("top.first", 64'hFFFF_FFFF_FFFF_F000, 4'd6, 1'b0);
        lookup("top.below", 64'hFFFF_FFFF_FFFF_EFFF, 4'd0, 1'b1);

        // Write and lock in the same cycle: write lands (PLIC disabled), then table locks
        cfg_write(4'd5, 64'h0C00_0000, 64'h0, 4'd5, 1'b1);
        chk("lock.locked", 64'(locked), 64'd1);
        chk("lock.same_cycle_err", 64'(cfg_err), 64'd0);
        lookup("lock.plic_off", 64'h0C00_0000, 4'd0, 1'b1);
        cfg_write(4'd4, 64'h1000_0000, 64'h0, 4'd4, 1'b0);
        chk("locked.err", 64'(cfg_err), 64'd1);
        step();
        chk("locked.err_clear", 64'(cfg_err), 64'd0);
        chk("locked.still", 64'(locked), 64'd1);
        lookup("locked.uart", 64'h1000_0100, 4'd4, 1'b0);

        // Reset while a result is being held drops it and restores the map
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 64'h8000_0000;
        step();
        req_valid  = 1'b0;
        chk("hold.valid", 64'(resp_valid), 64'd1);
        do_reset();
        resp_ready = 1'b1;
        chk("rst2.valid", 64'(resp_valid), 64'd0);
        chk("rst2.locked", 64'(locked), 64'd0);
        chk_miss("rst2.miss");
        lookup("rst2.uart", 64'h1000_0008, 4'd4, 1'b0);
        lookup("rst2.plic", 64'h0C00_0000, 4'd5, 1'b0);
        lookup("rst2.dram", 64'h8000_0000, 4'd0, 1'b0);
        lookup("rst2.top", 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_addr_decoder.md
Name: soc_addr_decoder

Overview:
Runtime-programmable, pipelined address decoder for the SoC crossbar, generalising the fixed SoC memory map to NUM_RULES regions targeting NUM_SLAVES ports.
- Resets to the standard SoC map: DRAM, GPIO, Ethernet, SPI, UART, PLIC, CLINT, ROM, Debug.
- Supports region reprogramming, lock-down and decode-miss error reporting.
- Sits between master address channels and the crossbar demux; one address lookup per handshake.

Parameters:
- ADDR_WIDTH, 64, address width.
- NUM_SLAVES, 9, number of target ports; IDX_W = max(1, $clog2(NUM_SLAVES)).
- NUM_RULES, 9, number of region table entries; RULE_W = max(1, $clog2(NUM_RULES)).
- DEFAULT_IDX, 0, slave index returned on a miss.
- RESET_BASE, SoC map bases in slave order (DRAM 0x8000_0000 … Debug 0x0), per-rule base loaded at reset.
- RESET_LEN, SoC map lengths (DRAM 0x4000_0000, GPIO 0x1000, Eth 0x10000, SPI 0x800000, UART 0x1000, PLIC 0x3FF_FFFF, CLINT 0xC0000, ROM 0x10000, Debug 0x1000), per-rule length loaded at reset.
- RESET_IDX, {8,7,…,0} (rule i targets slave i), per-rule slave loaded at reset.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  address valid
- req_ready_o  out  1  decoder can accept
- req_addr_i  in  ADDR_WIDTH  address to decode
- resp_valid_o  out  1  decode result valid
- resp_ready_i  in  1  consumer accepts result
- resp_idx_o  out  IDX_W  target slave index
- resp_decerr_o  out  1  no rule matched
- resp_addr_o  out  ADDR_WIDTH  address echoed with result
- cfg_we_i  in  1  rule write strobe
- cfg_rule_i  in  RULE_W  rule to write
- cfg_base_i  in  ADDR_WIDTH  new base
- cfg_len_i  in  ADDR_WIDTH  new length
- cfg_idx_i  in  IDX_W  new target slave
- cfg_lock_i  in  1  set lock (sticky until reset)
- cfg_err_o  out  1  one-cycle pulse: write rejected
- locked_o  out  1  table locked
- miss_cnt_o  out  32  decode-miss counter

Behaviour:
- One clock, clk_i; rst_i synchronous, active-high. Asserting it mid-transfer drops any held result.
- Reset:
  - table loaded from RESET_* parameters; locked_o=0.
  - resp_valid_o=0, resp_idx_o=0, resp_decerr_o=0, resp_addr_o=0.
  - cfg_err_o=0, miss_cnt_o=0.
- Datapath: one output register stage, 1-cycle latency. The result appears the cycle after the req handshake.
- req_ready_o = !resp_valid_o || resp_ready_i (combinational pass-through, no bubble). Full throughput of 1 lookup/cycle.
- Output stability: while resp_valid_o && !resp_ready_i, all resp_* outputs are held stable.
- Match rule r: len[r]!=0 && addr >= base[r] && addr < base[r]+len[r].
  - Sum is computed in ADDR_WIDTH+1 bits, so a region ending at 2^ADDR_WIDTH matches the top address.
  - len=0 disables the rule.
- Overlap: the lowest-numbered matching rule wins.
- Miss: resp_decerr_o=1, resp_idx_o=DEFAULT_IDX. miss_cnt_o increments on the req handshake and saturates at 0xFFFF_FFFF.
- Config write: cfg_we_i && !locked_o updates base/len/idx of cfg_rule_i at the clock edge.
  - A request accepted in the same cycle decodes with the old table.
  - cfg_rule_i >= NUM_RULES: write ignored, cfg_err_o pulses.
- Lock: cfg_lock_i sets locked_o the next cycle. Once locked, every cfg_we_i is ignored and cfg_err_o pulses the following cycle.
  - cfg_we_i and cfg_lock_i in the same unlocked cycle: the write takes effect, then the table locks.
- cfg_err_o is registered and high for exactly one cycle per rejected write.

Optional Feature:
- Macro: SOC_ADDR_DECODER_MISS_CNT_EN.
- Defined: miss_cnt_o implemented as specified.
- Undefined: no counter flops; miss_cnt_o tied to 0. All other behaviour unchanged.

Test Plan:
- Reset, req 0x8000_1000 → next cycle resp_valid_o=1, idx=0, decerr=0; req 0x1000_0FFF → idx=4; req 0x0000_0800 → idx=8.
- req 0x1000_1000 (gap after UART) → idx=DEFAULT_IDX(0), decerr=1, miss_cnt_o=1. Second miss → 2.
- Back-to-back reqs 0x4000_0000, 0x2000_0000 with resp_ready_i low 3 cycles → req_ready_o=0 and first result (idx=1) held stable; after release, results 1 then 3 with no bubble.
- Write rule 0 base=0x1000_0000 len=0x10 idx=2 (overlaps UART rule 4) → 0x1000_0008 gives idx=2 (rule 0 wins); 0x1000_0010 gives idx=4.
- Assert cfg_lock_i, then write rule 4 len=0 → cfg_err_o pulses one cycle, locked_o=1, 0x1000_0000 still gives idx=4. rst_i clears lock and restores map.
- Write cfg_rule_i=9 (NUM_RULES=9) → cfg_err_o pulse, table unchanged. Request with address 0xFFFF_FFFF_FFFF_FFFF after programming rule 1 base=0xFFFF_FFFF_FFFF_F000 len=0x1000 → idx per rule 1 target, decerr=0.
